fifo_param: RTL

Parametrised synchronous FIFO; the next generation of the team's 4×4-bit single-clock FIFO. It generalises data width and depth, and adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and optional sticky error flags. It sits between a producer and a consumer in the same clock domain, with show-ahead read data (the head word is visible on `rdata` whenever `empty` is low).

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_param_if.sv | 43 ++++
 rtl/fifo_ptr.sv | 34 +++
 rtl/fifo_param.sv | 93 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
package fifo_pkg;

  localparam int unsigned MinDepth     = 2;
  // Pointers carry one extra wrap bit above the memory index.
  localparam int unsigned PtrExtraBits = 1;

  function automatic int unsigned fifo_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for fifo_param; overflow/underflow exist only
// when FIFO_ERR_FLAGS_EN is defined.
interface fifo_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned AW = fifo_aw(DEPTH);

  logic             flush;
  logic [WIDTH-1:0] wdata;
  logic             wen;
  logic             full;
  logic             almost_full;
  logic [WIDTH-1:0] rdata;
  logic             ren;
  logic             empty;
  logic             almost_empty;
  logic [AW:0]      count;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output flush, wdata, wen, ren,
`ifdef FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  full, almost_full, rdata, empty, almost_empty, count
  );

  modport slave (
    input  flush, wdata, wen, ren,
`ifdef FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output full, almost_full, rdata, empty, almost_empty, count
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer for fifo_param: AW index bits plus one wrap bit,
// synchronous flush to zero taking priority over increment.
module fifo_ptr #(
  parameter int unsigned AW = 2
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        flush,
  input  logic        inc,
  output logic [AW:0] ptr
);

  logic [AW:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock show-ahead FIFO with count, almost flags and flush.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic          CLK,
  input logic          RESETN,
  fifo_param_if.slave  bus
);

  localparam int unsigned AW = fifo_aw(DEPTH);
  localparam int unsigned PW = AW + PtrExtraBits;

  localparam logic [PW-1:0] AfLevel = AF_LEVEL[PW-1:0];
  localparam logic [PW-1:0] AeLevel = AE_LEVEL[PW-1:0];

  logic [PW-1:0]    waddr, raddr;
  logic [PW-1:0]    count;
  logic             full, empty;
  logic             wvalid, rvalid;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (waddr == raddr);
  assign full  = (waddr[AW-1:0] == raddr[AW-1:0]) && (waddr[AW] != raddr[AW]);
  assign count = waddr - raddr;

  // Flush suppresses both accepts so nothing lands after the pointers clear.
  assign wvalid = bus.wen & ~full & ~bus.flush;
  assign rvalid = bus.ren & ~empty & ~bus.flush;

  fifo_ptr #(
    .AW (AW)
  ) u_wptr (
    .CLK    (CLK),
    .RESETN (RESETN),
    .flush  (bus.flush),
    .inc    (wvalid),
    .ptr    (waddr)
  );

  fifo_ptr #(
    .AW (AW)
  ) u_rptr (
    .CLK    (CLK),
    .RESETN (RESETN),
    .flush  (bus.flush),
    .inc    (rvalid),
    .ptr    (raddr)
  );

  always_ff @(posedge CLK) begin
    if (wvalid) begin
      mem[waddr[AW-1:0]] <= bus.wdata;
    end
  end

  assign bus.rdata        = mem[raddr[AW-1:0]];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AfLevel);
  assign bus.almost_empty = (count <= AeLevel);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wen && full) begin
        overflow_q <= 1'b1;
      end
      if (bus.ren && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule
